// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// The top-level build option BOOTH_SKIP_EN does not affect this package.
package booth_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int ACC_W     = DEF_WIDTH + 2;
   localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Booth pair is {q[0], q_1}: the current multiplier bit and the one shifted out before it.
   typedef enum logic [1:0] {
      PAIR_NOP0 = 2'b00,
      PAIR_ADD  = 2'b01,
      PAIR_SUB  = 2'b10,
      PAIR_NOP1 = 2'b11
   } pair_t;

   function automatic logic pair_active(input pair_t pr);
      return (pr == PAIR_ADD) || (pr == PAIR_SUB);
   endfunction

endpackage

// File: rtl/booth_mul_ctrl_if.sv
// Start/done handshake bundle between the Booth multiplier and the logic around it.
// Handshake: start is sampled only while the multiplier is idle (busy=0); an accepted start
// raises busy on that edge, done pulses for one cycle when p is valid, and p holds until the
// next accepted start. start seen while busy=1 is dropped, never queued.
interface booth_mul_ctrl_if #(
   parameter int WIDTH = 4
);

   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   p;

   modport master (
      output start, a, b,
      input  busy, done, p
   );

   modport slave (
      input  start, a, b,
      output busy, done, p
   );

endinterface

// File: rtl/addsub_unit.sv
// Ripple-carry add/subtract; cin doubles as the subtract select (b is inverted and cin adds the +1).
// The final carry-out is intentionally dropped: the caller sizes the width so it never matters.
module addsub_unit #(
   parameter int ACC_W = 6
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   input  logic             cin,
   output logic [ACC_W-1:0] sum
);

   always_comb begin
      logic c;
      logic bb;
      c   = cin;
      bb  = 1'b0;
      sum = '0;
      for (int i = 0; i < ACC_W; i++) begin
         bb     = b[i] ^ cin;
         sum[i] = a[i] ^ bb ^ c;
         c      = (a[i] & bb) | (a[i] & c) | (bb & c);
      end
   end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Sequential radix-2 Booth multiplier: one shared add/subtract unit, WIDTH add+shift iterations.
// Build option BOOTH_SKIP_EN: bypass the ADD state for 00/11 Booth pairs (variable latency).
module booth_mul_ctrl
   import booth_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   booth_mul_ctrl_if.slave        bus,
   output state_t                 dbg_state
);

   localparam int AW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH + 1);

   state_t             state;
   state_t             state_next;

   logic [AW-1:0]      acc;
   logic [AW-1:0]      m;
   logic [AW-1:0]      sum;
   logic [WIDTH-1:0]   q;
   logic               q_1;
   logic [CW-1:0]      count;
   logic [CW-1:0]      count_inc;
   logic [2*WIDTH-1:0] p_q;

   pair_t              pair;
   logic               sub;
   logic               last;

   logic [AW-1:0]      acc_sh;
   logic [WIDTH-1:0]   q_sh;
   logic               q_1_sh;

   assign pair = pair_t'({q[0], q_1});
   assign sub  = (pair == PAIR_SUB);

   // Arithmetic right shift of {acc,q,q_1}: acc MSB replicated, old q_1 falls off the end.
   assign {acc_sh, q_sh, q_1_sh} = {acc[AW-1], acc, q};

   assign count_inc = count + 1'b1;
   assign last      = (count_inc == CW'(WIDTH));

   addsub_unit #(
      .ACC_W (AW)
   ) u_addsub (
      .a   (acc),
      .b   (m),
      .cin (sub),
      .sum (sum)
   );

`ifdef BOOTH_SKIP_EN
   pair_t pair_after_shift;
   assign pair_after_shift = pair_t'({q_sh[0], q_1_sh});
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
`ifdef BOOTH_SKIP_EN
               // q_1 starts at 0, so the first pair is {b[0],0}.
               state_next = bus.b[0] ? ADD : SHIFT;
`else
               state_next = ADD;
`endif
            end
         end
         ADD: begin
            state_next = SHIFT;
         end
         SHIFT: begin
            if (last) begin
               state_next = DONE;
            end else begin
`ifdef BOOTH_SKIP_EN
               state_next = pair_active(pair_after_shift) ? ADD : SHIFT;
`else
               state_next = ADD;
`endif
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         q     <= '0;
         q_1   <= 1'b0;
         m     <= '0;
         count <= '0;
         p_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  m     <= {{2{bus.a[WIDTH-1]}}, bus.a};
                  q     <= bus.b;
                  acc   <= '0;
                  q_1   <= 1'b0;
                  count <= '0;
               end
            end
            ADD: begin
               if (pair_active(pair)) begin
                  acc <= sum;
               end
            end
            SHIFT: begin
               acc   <= acc_sh;
               q     <= q_sh;
               q_1   <= q_1_sh;
               count <= count_inc;
               if (last) begin
                  p_q <= {acc_sh[WIDTH-1:0], q_sh};
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy  = (state != IDLE);
   assign bus.done  = (state == DONE);
   assign bus.p     = p_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed self-checking bench for booth_mul_ctrl (WIDTH=4); adapts latency checks to BOOTH_SKIP_EN.
module tb_booth_mul_ctrl;
   import booth_pkg::*;

`ifdef BOOTH_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic   clk = 1'b0;
   logic   rst;
   state_t dbg_state;
   int     vectors = 0;
   int     miscompares = 0;

   booth_mul_ctrl_if #(.WIDTH(4)) bus ();

   booth_mul_ctrl #(
      .WIDTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Expected capture-to-done latency: 2*W, or W plus one per 01/10 Booth pair when skipping.
   function automatic int exp_lat(input logic [3:0] bv);
      int   n;
      logic prev;
      n    = 0;
      prev = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bv[i] != prev) n++;
         prev = bv[i];
      end
      return SKIP ? 4 + n : 8;
   endfunction

   task automatic start_op(input logic [3:0] ai, input logic [3:0] bi);
      @(negedge clk);
      bus.a     = ai;
      bus.b     = bi;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Entered at the negedge after the capture edge; lat counts posedges since capture.
   task automatic wait_done(output int lat);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      #12;
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      vectors++;
      if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      vectors++;
      if (bus.p !== 8'h00) begin miscompares++; $display("FAIL reset_p: got %h expected 00", bus.p); end
      vectors++;
      if (dbg_state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_corner;
      logic [3:0] ta [3];
      logic [3:0] tb [3];
      logic [7:0] tp [3];
      int         lat;
      ta = '{4'h8, 4'h8, 4'h7};
      tb = '{4'h8, 4'h7, 4'hF};
      tp = '{8'h40, 8'hC8, 8'hF9};
      for (int k = 0; k < 3; k++) begin
         start_op(ta[k], tb[k]);
         wait_done(lat);
         vectors++;
         if (lat != exp_lat(tb[k])) begin
            miscompares++;
            $display("FAIL corner_lat[%0d]: got %0d expected %0d", k, lat, exp_lat(tb[k]));
         end
         vectors++;
         if (bus.p !== tp[k]) begin
            miscompares++;
            $display("FAIL corner_p[%0d]: got %h expected %h", k, bus.p, tp[k]);
         end
         @(negedge clk);
         vectors++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL corner_pulse[%0d]: done=%b busy=%b expected 0 0", k, bus.done, bus.busy);
         end
      end
   endtask

   task automatic test_midrun_reset;
      int lat;
      start_op(4'd5, 4'd3);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
      vectors++;
      if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
      vectors++;
      if (bus.p !== 8'h00) begin miscompares++; $display("FAIL midrst_p: got %h expected 00", bus.p); end
      vectors++;
      if (dbg_state !== IDLE) begin miscompares++; $display("FAIL midrst_state: got %0d expected %0d", dbg_state, IDLE); end
      @(negedge clk);
      rst = 1'b0;
      start_op(4'd3, 4'd5);
      wait_done(lat);
      vectors++;
      if (lat != exp_lat(4'd5)) begin miscompares++; $display("FAIL midrst_lat: got %0d expected %0d", lat, exp_lat(4'd5)); end
      vectors++;
      if (bus.p !== 8'h0F) begin miscompares++; $display("FAIL midrst_p2: got %h expected 0f", bus.p); end
      @(negedge clk);
   endtask

   task automatic test_start_held;
      int lat;
      @(negedge clk);
      bus.a     = 4'd2;
      bus.b     = 4'd2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.a = 4'd6;
      bus.b = 4'd6;
      wait_done(lat);
      vectors++;
      if (lat != exp_lat(4'd2)) begin miscompares++; $display("FAIL held_lat: got %0d expected %0d", lat, exp_lat(4'd2)); end
      vectors++;
      if (bus.p !== 8'h04) begin miscompares++; $display("FAIL held_p: got %h expected 04", bus.p); end
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL held_gap: busy=%b expected 0", bus.busy); end
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL held_recapture: busy=%b expected 1", bus.busy); end
      bus.start = 1'b0;
      wait_done(lat);
      vectors++;
      if (bus.p !== 8'h24) begin miscompares++; $display("FAIL held_p2: got %h expected 24", bus.p); end
      @(negedge clk);
   endtask

   task automatic test_exhaustive;
      int         lat;
      logic [3:0] av;
      logic [3:0] bv;
      logic [7:0] expp;
      @(negedge clk);
      for (int ai = -8; ai < 8; ai++) begin
         for (int bi = -8; bi < 8; bi++) begin
            av        = 4'(ai);
            bv        = 4'(bi);
            expp      = 8'(ai * bi);
            bus.a     = av;
            bus.b     = bv;
            bus.start = 1'b1;
            @(negedge clk);
            vectors++;
            if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL exh_busy %0d*%0d: busy=%b expected 1", ai, bi, bus.busy); end
            wait_done(lat);
            vectors++;
            if (bus.p !== expp) begin miscompares++; $display("FAIL exh_p %0d*%0d: got %h expected %h", ai, bi, bus.p, expp); end
            vectors++;
            if (lat != exp_lat(bv)) begin miscompares++; $display("FAIL exh_lat %0d*%0d: got %0d expected %0d", ai, bi, lat, exp_lat(bv)); end
            @(negedge clk);
            vectors++;
            if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL exh_gap %0d*%0d: busy=%b expected 0", ai, bi, bus.busy); end
         end
      end
      bus.start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_skip_latency;
      logic [3:0] tb [3];
      logic [7:0] tp [3];
      int         tl [3];
      int         lat;
      tb = '{4'b0000, 4'b0101, 4'b1111};
      tp = '{8'h00, 8'h0F, 8'hFD};
      tl = '{SKIP ? 4 : 8, 8, SKIP ? 5 : 8};
      for (int k = 0; k < 3; k++) begin
         start_op(4'd3, tb[k]);
         wait_done(lat);
         vectors++;
         if (lat != tl[k]) begin miscompares++; $display("FAIL skip_lat[%0d]: got %0d expected %0d", k, lat, tl[k]); end
         vectors++;
         if (bus.p !== tp[k]) begin miscompares++; $display("FAIL skip_p[%0d]: got %h expected %h", k, bus.p, tp[k]); end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_corner();
      test_midrun_reset();
      test_start_held();
      test_exhaustive();
      test_skip_latency();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
